// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with word-serial miss handling.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_dm_wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_NUM   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] mem_din,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFS_W - 2;

  // state  | meaning
  // IDLE   | combinational lookup, hits complete, misses start here
  // WB     | writing the dirty victim line back, one word per ack
  // REFILL | fetching the requested line, one word per ack
  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  state_t                 state;
  logic [OFS_W-1:0]       cnt;
  logic [LINE_NUM-1:0]    valid;
  logic [LINE_NUM-1:0]    dirty;
  logic [TAG_W-1:0]       tag_mem  [LINE_NUM];
  logic [DATA_WIDTH-1:0]  data_mem [LINE_NUM*LINE_WORDS];
  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_idx;

  logic [TAG_W-1:0]       a_tag;
  logic [IDX_W-1:0]       a_idx;
  logic [OFS_W-1:0]       a_ofs;
  logic                   hit;
  logic                   miss;
  logic                   last;
  logic                   unused_addr;

  assign a_tag       = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign a_idx       = cpu_addr[OFS_W+2 +: IDX_W];
  assign a_ofs       = cpu_addr[2 +: OFS_W];
  assign unused_addr = ^cpu_addr[1:0];

  assign hit  = cpu_req && (state == IDLE) && valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign miss = cpu_req && (state == IDLE) && !hit;
  assign last = &cnt;

  assign cpu_stall = (state != IDLE) || miss;
  assign cpu_dout  = hit ? data_mem[{a_idx, a_ofs}] : '0;

  // The miss line is latched so a dropped cpu_req cannot disturb a running burst.
  assign mem_req  = (state != IDLE);
  assign mem_we   = (state == WB);
  assign mem_addr = {((state == WB) ? tag_mem[req_idx] : req_tag), req_idx, cnt, 2'b00};
  assign mem_dout = data_mem[{req_idx, cnt}];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit && cpu_we) dirty[a_idx] <= 1'b1;
          if (miss) begin
            req_tag <= a_tag;
            req_idx <= a_idx;
            cnt     <= '0;
            state   <= (valid[a_idx] && dirty[a_idx]) ? WB : REFILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) state <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit && cpu_we) data_mem[{a_idx, a_ofs}] <= cpu_din;
      if ((state == REFILL) && mem_ack) begin
        data_mem[{req_idx, cnt}] <= mem_din;
        if (last) tag_mem[req_idx] <= req_tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic        just_refilled;

  // The IDLE cycle right after a refill completes the original miss, not a new hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q         <= '0;
      miss_q        <= '0;
      just_refilled <= 1'b0;
    end else begin
      just_refilled <= (state == REFILL) && mem_ack && last;
      if (hit && !just_refilled) hit_q <= hit_q + 32'd1;
      if (miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_dm_wb.sv
// Bench for cache_dm_wb: directed vector table, multi-cycle corner sequences and
// random accesses checked against a flat-memory / line-residency reference model.
module tb_cache_dm_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_ack;
  logic [31:0] hit_cnt, miss_cnt;

  cache_dm_wb dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main memory model ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       xlog[$];
  int unsigned mem_model[int unsigned];
  int          mem_delay = 1;

  function automatic int unsigned init_val(input int unsigned a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic int unsigned mem_rd(input int unsigned a);
    return mem_model.exists(a) ? mem_model[a] : init_val(a);
  endfunction

  // Memory answers after mem_delay idle request cycles per word; checks request hold.
  initial begin
    int          w;
    bit          pend;
    logic [31:0] p_addr, p_dout;
    logic        p_we;
    mem_ack = 1'b0;
    mem_din = '0;
    w = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ack = 1'b0;
        w = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_we", 32'(mem_we), 32'(p_we));
          if (mem_we) chk("hold_dout", mem_dout, p_dout);
        end
        if (w >= mem_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_dout;
          else mem_din = mem_rd(mem_addr);
          xlog.push_back('{mem_we, mem_addr, (mem_we ? mem_dout : mem_din)});
          w = 0;
          pend = 1'b0;
        end else begin
          mem_ack = 1'b0;
          w++;
          pend = 1'b1;
          p_addr = mem_addr;
          p_dout = mem_dout;
          p_we = mem_we;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // CPU view is a flat memory; the cache is only tracked as which tag each line holds.
  bit          m_valid[64];
  bit          m_dirty[64];
  int unsigned m_tag[64];
  int unsigned golden[int unsigned];
  int          exp_hits, exp_misses;

  function automatic int unsigned golden_rd(input int unsigned a);
    return golden.exists(a) ? golden[a] : mem_rd(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    golden.delete();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic predict(input bit we, input int unsigned a, input int unsigned din, input int d,
                         output int unsigned e_dout, output int e_stalls, output int e_xfers);
    int unsigned t;
    int          ix;
    t  = a >> 10;
    ix = int'((a >> 4) & 63);
    if (m_valid[ix] && m_tag[ix] == t) begin
      e_stalls = 0;
      e_xfers  = 0;
      exp_hits++;
    end else begin
      e_xfers  = (m_valid[ix] && m_dirty[ix]) ? 8 : 4;
      e_stalls = 1 + e_xfers * (d + 1);
      exp_misses++;
      m_valid[ix] = 1'b1;
      m_tag[ix]   = t;
      m_dirty[ix] = 1'b0;
    end
    e_dout = golden_rd(a);
    if (we) begin
      m_dirty[ix] = 1'b1;
      golden[a]   = din;
    end
  endtask

  // ---------------- CPU driver ----------------
  // Entered and left 1 time unit after a rising edge.
  task automatic cpu_access(input bit we, input int unsigned a, input int unsigned din,
                            output int unsigned got, output int stalls, output int start);
    bit done;
    start  = xlog.size();
    stalls = 0;
    got    = 0;
    done   = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = din;
    for (int c = 0; c < 400; c++) begin
      #2;
      if (!cpu_stall) begin
        got  = cpu_dout;
        done = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    chk("access_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic do_access(input bit we, input int unsigned a, input int unsigned din, input int d,
                           output int unsigned got, output int stalls, output int start,
                           output int unsigned e_dout, output int e_stalls, output int e_xfers);
    mem_delay = d;
    predict(we, a, din, d, e_dout, e_stalls, e_xfers);
    cpu_access(we, a, din, got, stalls, start);
  endtask

  task automatic chk_burst(input string name, input int start, input int nwb, input int unsigned wb_base,
                           input int nrd, input int unsigned rd_base);
    int          bad;
    bit          ew;
    int unsigned ea;
    bad = 0;
    if (xlog.size() - start != nwb + nrd) bad++;
    else begin
      for (int k = 0; k < nwb + nrd; k++) begin
        ew = (k < nwb);
        ea = ew ? wb_base + 4 * k : rd_base + 4 * (k - nwb);
        if (xlog[start + k].we != ew || xlog[start + k].addr !== ea) bad++;
      end
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic chk_stats(input string name, input int h, input int m);
`ifdef CACHE_STATS_EN
    chk({name, "_hit"}, hit_cnt, 32'(h));
    chk({name, "_miss"}, miss_cnt, 32'(m));
`else
    chk({name, "_hit"}, hit_cnt, 32'd0);
    chk({name, "_miss"}, miss_cnt, 32'd0);
`endif
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          we;
    int unsigned addr;
    int unsigned din;
    int          d;
    int unsigned exp_dout;
    int          exp_stalls;
    int          nwb;
    int unsigned wb_base;
    int          nrd;
    int unsigned rd_base;
  } vec_t;

  vec_t vt[7];

  initial begin
    int unsigned got, e_dout;
    int          stalls, start, e_stalls, e_xfers;

    vt[0] = '{0, 32'h000, 0,            1, 32'h1111_1111, 9,  0, 0,     4, 32'h000};
    vt[1] = '{0, 32'h004, 0,            1, 32'h1111_1112, 0,  0, 0,     0, 0};
    vt[2] = '{1, 32'h008, 32'h2222_2222, 1, 0,            0,  0, 0,     0, 0};
    vt[3] = '{0, 32'h008, 0,            1, 32'h2222_2222, 0,  0, 0,     0, 0};
    vt[4] = '{0, 32'h408, 0,            1, 32'h3333_3333, 17, 4, 32'h0, 4, 32'h400};
    vt[5] = '{0, 32'h008, 0,            1, 32'h2222_2222, 9,  0, 0,     4, 32'h000};
    vt[6] = '{0, 32'h030, 0,            0, init_val(32'h30), 5, 0, 0,   4, 32'h030};

    for (int k = 0; k < 4; k++) begin
      mem_model[4 * k]         = 32'h1111_1111 + k;
      mem_model[32'h400 + 4 * k] = 32'h3333_3331 + k;
    end

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_dout", cpu_dout, 32'd0);
    chk_stats("rst_stats", 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      do_access(vt[i].we, vt[i].addr, vt[i].din, vt[i].d, got, stalls, start, e_dout, e_stalls, e_xfers);
      if (!vt[i].we) chk($sformatf("vec%0d_dout", i), got, vt[i].exp_dout);
      chk($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(vt[i].exp_stalls));
      chk_burst($sformatf("vec%0d_burst", i), start, vt[i].nwb, vt[i].wb_base, vt[i].nrd, vt[i].rd_base);
      if (i == 4) begin
        chk_stats("stats_after_evict", 3, 2);
        chk("wb_word0", mem_rd(32'h0), 32'h1111_1111);
        chk("wb_word1", mem_rd(32'h4), 32'h1111_1112);
        chk("wb_word2", mem_rd(32'h8), 32'h2222_2222);
        chk("wb_word3", mem_rd(32'hC), 32'h1111_1114);
      end
    end

    // Slow memory: 3 wait cycles per word, clean then dirty miss on line 1.
    do_access(1, 32'h010, 32'hCAFE_0010, 3, got, stalls, start, e_dout, e_stalls, e_xfers);
    chk("slow_clean_stalls", 32'(stalls), 32'd17);
    chk_burst("slow_clean_burst", start, 0, 0, 4, 32'h010);
    do_access(0, 32'h410, 0, 3, got, stalls, start, e_dout, e_stalls, e_xfers);
    chk("slow_dirty_stalls", 32'(stalls), 32'd33);
    chk("slow_dirty_dout", got, init_val(32'h410));
    chk_burst("slow_dirty_burst", start, 4, 32'h010, 4, 32'h410);
    chk("slow_wb_data", mem_rd(32'h010), 32'hCAFE_0010);

    // Reset after the second refill ack abandons the burst.
    mem_delay = 1;
    start = xlog.size();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h020;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (xlog.size() - start >= 2) break;
    end
    chk("rst_mid_acks", 32'(xlog.size() - start), 32'd2);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #2;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(cpu_stall), 32'd0);
    chk_stats("rst_mid_stats", 0, 0);
    @(posedge clk); #1;
    do_access(0, 32'h020, 0, 1, got, stalls, start, e_dout, e_stalls, e_xfers);
    chk("rst_mid_refill_stalls", 32'(stalls), 32'd9);
    chk("rst_mid_refill_dout", got, init_val(32'h020));
    chk_burst("rst_mid_refill_burst", start, 0, 0, 4, 32'h020);

    // Random traffic over 4 tags x 4 lines to force hits, clean and dirty evictions.
    for (int n = 0; n < 300; n++) begin
      bit          we;
      int unsigned a, din;
      int          d;
      we  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      din = $urandom;
      d   = int'($urandom_range(0, 2));
      do_access(we, a, din, d, got, stalls, start, e_dout, e_stalls, e_xfers);
      if (!we) chk("rnd_dout", got, e_dout);
      chk("rnd_stalls", 32'(stalls), 32'(e_stalls));
      chk("rnd_xfers", 32'(xlog.size() - start), 32'(e_xfers));
    end
    chk_stats("final_stats", exp_hits, exp_misses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/cache_dm_wb.md
# cache_dm_wb

Parametrised direct-mapped, write-back, write-allocate data cache that sits between the pipelined CPU's MEM stage and main memory. It generalises the single cache line to a configurable number of lines and words per line. It adds a miss-handling state machine that writes back dirty victims and refills lines over a word-serial request/acknowledge memory port. While a miss is being serviced, the cache stalls the pipeline.

## Interface
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width. Must be 32.
- LINE_NUM, 64, number of lines. Must be a power of two, ≥2.
- LINE_WORDS, 4, words per line. Must be a power of two, ≥2.
- Derived widths:
  - OFS_W = log2(LINE_WORDS)
  - IDX_W = log2(LINE_NUM)
  - TAG_W = ADDR_WIDTH − IDX_W − OFS_W − 2
  - With the defaults, TAG_W = 22.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  byte address. Bits [1:0] are ignored.
- cpu_din  in  DATA_WIDTH  write data.
- cpu_dout  out  DATA_WIDTH  read data.
- cpu_stall  out  1  access not complete this cycle.
- mem_req  out  1  memory word request.
- mem_we  out  1  1 = write-back word, 0 = refill word.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_dout  out  DATA_WIDTH  write-back data.
- mem_din  in  DATA_WIDTH  refill data. Valid when mem_ack = 1.
- mem_ack  in  1  current word accepted or returned.
- hit_cnt  out  32  hit counter (see Configuration).
- miss_cnt  out  32  miss counter (see Configuration).

## Operation
- **Address split:**
  - tag = addr[ADDR_WIDTH−1 : ADDR_WIDTH−TAG_W]
  - index = next IDX_W bits below the tag
  - word offset = addr[OFS_W+1 : 2]
- **Per-line state:** valid bit, dirty bit, tag, and LINE_WORDS data words.
- **Lookup is combinational in IDLE.** hit = cpu_req & valid[idx] & (tag[idx] == addr tag).
- **Read hit:** cpu_dout = the addressed word in the same cycle; cpu_stall = 0.
- **Write hit:** the word is written at the clock edge and dirty[idx] is set; cpu_stall = 0.
- **Miss** (cpu_req & !hit in IDLE): cpu_stall = 1 in the same cycle.
  - If the victim line is valid and dirty, go to WB.
  - Otherwise, go to REFILL.
- **State machine** (states IDLE, WB, REFILL) with a word counter of width OFS_W:
  - **WB:**
    - mem_req = 1, mem_we = 1.
    - mem_addr = {victim tag, idx, cnt, 2'b00}; mem_dout = the victim word at cnt.
    - Each cycle with mem_ack = 1: cnt increments.
    - On the ack for the last word: cnt returns to 0, go to REFILL.
  - **REFILL:**
    - mem_req = 1, mem_we = 0.
    - mem_addr = {request tag, idx, cnt, 2'b00}.
    - Each cycle with mem_ack = 1: mem_din is written into word cnt.
    - On the ack for the last word: set valid, clear dirty, load the tag, go to IDLE.
  - **Back in IDLE,** the held request hits and completes (a write then sets dirty).
- **Handshake rules:**
  - mem_req, mem_we, mem_addr and mem_dout are held stable until the cycle in which mem_ack is sampled high.
  - mem_req stays high across consecutive words of the same burst.
  - mem_req = 0 in IDLE.
  - mem_ack while mem_req = 0 is ignored.
- **CPU side:** the CPU holds cpu_req, cpu_we, cpu_addr and cpu_din stable while cpu_stall = 1. Once started, a miss sequence always runs to completion, even if cpu_req drops.
- **Outputs when idle:** cpu_dout = 0 when cpu_req = 0 or during a miss.

## Timing
- **Hit latency:** 0 extra cycles.
- **Miss latency:**
  - Clean victim: LINE_WORDS acks + 1 cycle (stall cycles).
  - Dirty victim: 2·LINE_WORDS acks + 1 cycle.
  - With a zero-wait-state memory (ack the same cycle as request), a clean miss with the defaults stalls 5 cycles.
- **Reset** (rst = 1 at an edge): state = IDLE, cnt = 0, all valid and dirty bits cleared, counters cleared. From the next cycle, mem_req = 0 and cpu_stall = 0 unless a new miss is presented.
  - Tag and data arrays are not cleared.
  - Reset during WB or REFILL abandons the burst. Memory must tolerate a dropped request; a line that was partially written back is lost.
- **Reset priority:** rst has priority over mem_ack and over the CPU request in the same cycle.

## Configuration
- **CACHE_STATS_EN**
  - **Defined:**
    - hit_cnt increments on every IDLE cycle in which a request hits and did not just finish a refill.
    - miss_cnt increments once per IDLE→WB or IDLE→REFILL transition.
    - Both counters wrap modulo 2^32.
  - **Not defined:** hit_cnt and miss_cnt are constant 0 and no counter flops are synthesised.

## Test plan
Default parameters; memory acks on the cycle after mem_req unless stated otherwise.
- **Cold miss:** After reset, read 0x00000000, memory returns 0x11111111, 0x11111112, 0x11111113 and 0x11111114 → 4 reads at 0x0/0x4/0x8/0xC with mem_we = 0 and no write-back. Then cpu_dout = 0x11111111 with stall low. Next, read 0x4 → 0x11111112 with zero stall.
- **Write hit:** write 0x22222222 to 0x00000008 → no memory traffic, cpu_stall = 0. Reading back 0x8 returns 0x22222222.
- **Dirty eviction:** read 0x00000408 (same index 0, tag 1).
  - 4 writes at 0x0..0xC with data 0x11111111, 0x11111112, 0x22222222, 0x11111114.
  - Then 4 reads at 0x400..0x40C.
  - Reading 0x8 afterwards misses again.
- **Slow memory:** mem_ack delayed 3 cycles per word → mem_addr and mem_dout stay stable during the wait, the burst still contains exactly 4 words, and the stall count matches.
- **Reset mid-refill:** assert rst after the 2nd refill ack → mem_req = 0 and cpu_stall = 0 the next cycle. A subsequent read of the same address misses and performs a full 4-word refill.
- **Stats (CACHE_STATS_EN defined):** after the scenarios "cold miss" through "dirty eviction" → hit_cnt = 3, miss_cnt = 2. With the macro undefined, both counters read 0.
